// File: rtl/instr_fetch_seq_if.sv
// Bundle of the signals between the fetch sequencer, instruction memory, instruction register
// and execute stage; master is the sequencer side.
interface instr_fetch_seq_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 4
);
  logic               start;
  logic               stop;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_data;
  logic [INSTR_W-1:0] ir_data;
  logic               ir_load;
  logic               exec_done;
  logic               jump;
  logic [ADDR_W-1:0]  jump_addr;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               mem_err;
  logic               halted;

  modport master (
    input  start, stop, mem_ready, mem_data, exec_done, jump, jump_addr,
    output mem_addr, mem_rd, ir_data, ir_load, pc, busy, mem_err, halted
  );

  modport slave (
    output start, stop, mem_ready, mem_data, exec_done, jump, jump_addr,
    input  mem_addr, mem_rd, ir_data, ir_load, pc, busy, mem_err, halted
  );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: PC, memory read with timeout, IR load strobe, exec handshake.
// Define HALT_DETECT_EN to stop on an all-ones instruction word and raise a sticky halted flag.
module instr_fetch_seq #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_seq_if.master  bus
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StLoad,
    StExec
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic               mem_rd_q;
  logic [INSTR_W-1:0] ir_data_q;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               err_q;
  logic               halted_q;
  logic               halt_word;
  logic               fetch_hit;
  logic               fetch_timeout;

  assign fetch_hit     = (state_q == StFetch) && bus.mem_ready;
  assign fetch_timeout = (state_q == StFetch) && !bus.mem_ready && (cnt_q == CntLast);

`ifdef HALT_DETECT_EN
  assign halt_word = (ir_data_q == {INSTR_W{1'b1}});
`else
  assign halt_word = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !err_q && !halted_q) state_d = StFetch;
      end
      StFetch: begin
        // A late mem_ready on the final wait cycle still wins over the timeout.
        if (bus.mem_ready)  state_d = StLoad;
        else if (fetch_timeout) state_d = StIdle;
      end
      StLoad: begin
        state_d = halt_word ? StIdle : StExec;
      end
      StExec: begin
        if (bus.exec_done) state_d = bus.stop ? StIdle : StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values
  always_comb begin
    pc_d = pc_q;
    if (fetch_hit) pc_d = pc_q + ADDR_W'(1);
    // Jump target replaces the increment already applied during the fetch.
    if ((state_q == StExec) && bus.exec_done && bus.jump) pc_d = bus.jump_addr;

    cnt_d = '0;
    if ((state_q == StFetch) && (state_d == StFetch)) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      ir_data_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      mem_rd_q <= (state_d == StFetch);
      // Address is latched on entry so it stays stable for the whole fetch.
      if ((state_q != StFetch) && (state_d == StFetch)) mem_addr_q <= pc_d;
      if (fetch_hit) ir_data_q <= bus.mem_data;
      if (fetch_timeout) err_q <= 1'b1;
    end
  end

`ifdef HALT_DETECT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
    end else if ((state_q == StLoad) && halt_word) begin
      halted_q <= 1'b1;
    end
  end
`else
  assign halted_q = 1'b0;
`endif

  // Outputs
  always_comb begin
    bus.ir_load  = (state_q == StLoad);
    bus.busy     = (state_q != StIdle);
    bus.mem_rd   = mem_rd_q;
    bus.mem_addr = mem_addr_q;
    bus.ir_data  = ir_data_q;
    bus.pc       = pc_q;
    bus.mem_err  = err_q;
    bus.halted   = halted_q;
  end

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Fetch sequencer that drives the instruction register.
- Holds the program counter and issues read requests to instruction memory.
- Captures each returned instruction word, then presents it with a one-cycle load strobe to the instruction register's data/enable inputs.
- Waits for the execute stage to finish before fetching the next word; supports jump redirect, stop, and memory-timeout error.

Parameters:
- ADDR_W, 8, program counter / memory address width.
- INSTR_W, 4, instruction word width; matches instruction register width.
- TIMEOUT, 15, max cycles to wait for mem_ready before flagging error; must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin fetching from current pc; sampled only in IDLE.
- stop  in  1  return to IDLE after current instruction completes.
- mem_addr  out  ADDR_W  instruction memory address.
- mem_rd  out  1  read request.
- mem_ready  in  1  memory data valid this cycle.
- mem_data  in  INSTR_W  instruction memory read data.
- ir_data  out  INSTR_W  captured instruction, to instruction register data input.
- ir_load  out  1  one-cycle load strobe, to instruction register enable.
- exec_done  in  1  execute stage finished current instruction.
- jump  in  1  redirect; sampled only with exec_done.
- jump_addr  in  ADDR_W  redirect target.
- pc  out  ADDR_W  current program counter.
- busy  out  1  high in any state other than IDLE.
- mem_err  out  1  sticky timeout error.
- halted  out  1  HALT opcode seen; constant 0 without macro.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, pc=0, ir_data=0, ir_load=0, mem_rd=0, mem_addr=0, mem_err=0, halted=0, timeout counter=0. Reset has priority over every other input, in any state, including mid-wait.
- States: IDLE, FETCH, LOAD, EXEC.
- IDLE: busy=0.
  - start=1 -> FETCH.
  - start is ignored while mem_err=1; mem_err clears only on reset.
- FETCH:
  - mem_rd=1, mem_addr=pc, both registered and stable for the whole state.
  - On mem_ready=1: ir_data<=mem_data, pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), counter<=0, next state LOAD.
  - Else counter increments.
  - If counter reaches TIMEOUT with mem_ready=0: mem_err<=1, mem_rd<=0, next state IDLE; pc is unchanged.
  - A mem_ready arriving on the same cycle the counter reaches TIMEOUT counts as success.
- LOAD: ir_load=1 for exactly one cycle, mem_rd=0, then EXEC.
  - Fetch latency is 1 cycle from mem_ready sampled to ir_load high.
- EXEC: ir_load=0; wait for exec_done=1.
  - On exec_done: if jump=1, pc<=jump_addr (overrides the increment already done); otherwise pc is unchanged.
  - Then: if stop=1 -> IDLE, else -> FETCH.
  - jump and stop together: pc is redirected and the state goes to IDLE.
  - exec_done seen in any other state is ignored.
- stop is not sampled outside EXEC.
- mem_ready outside FETCH is ignored.
- ir_data holds its value until the next capture.

Optional Feature:
- Macro: HALT_DETECT_EN.
- With the macro: a captured word equal to all-ones (4'hF at default width) is still loaded into the instruction register via the LOAD state. After it, the block goes to IDLE instead of EXEC and sets halted=1.
  - halted is sticky until reset.
  - start is ignored while halted=1.
- Without the macro: all-ones is an ordinary instruction and halted is tied 0.

Test Plan:
- Reset then start, memory returns 4'h3 with mem_ready the cycle after mem_rd -> mem_addr=0, ir_data=3, ir_load high exactly 1 cycle, pc=1; pulsing exec_done fetches address 1.
- exec_done with jump=1, jump_addr=8'h40 -> next mem_addr=8'h40; after capture pc=8'h41.
- pc=8'hFF, fetch completes -> pc wraps to 8'h00.
- mem_ready held low for TIMEOUT(15) cycles -> mem_err=1, mem_rd=0, state IDLE, pc unchanged; a later start is ignored; rst_n low clears mem_err.
- exec_done with stop=1 -> busy=0 next cycle, no mem_rd; start resumes at the current pc. rst_n low during a FETCH wait -> all outputs return to reset values next cycle.
- With HALT_DETECT_EN, memory returns 4'hF -> ir_load pulses with ir_data=F, halted=1, busy=0, no further mem_rd. Without the macro -> normal EXEC wait, halted=0.
